// File: rtl/pulse_timer_sweep.sv
// Pulse channel period timer, 8-step sequencer position and frequency sweep unit.
// The timer counts down on apu_clk ticks and strobes next_step on expiry; the
// sweep unit periodically retargets the period by adding or subtracting a
// shifted copy of itself.
// Build option: define PULSE_SWEEP_UNIT_EN to include the sweep unit. Without
// it the period changes only through CPU writes and sweep_update stays low.
module pulse_timer_sweep #(
   parameter int TIMER_W  = 11,
   parameter int SHIFT_W  = 3,
   parameter int DIV_W    = 3,
   parameter int NEG_ONES = 0,
   parameter int MUTE_MIN = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cpu_en,
   input  logic               apu_clk,
   input  logic               half_frame,
   input  logic               set_period_low,
   input  logic [7:0]         period_low_in,
   input  logic               set_period_high,
   input  logic [TIMER_W-9:0] period_high_in,
   input  logic               sweep_write,
   input  logic               sweep_en_in,
   input  logic [DIV_W-1:0]   sweep_period_in,
   input  logic               sweep_negate_in,
   input  logic [SHIFT_W-1:0] sweep_shift_in,
   output logic               next_step,
   output logic [2:0]         seq_step,
   output logic               mute,
   output logic [TIMER_W-1:0] period,
   output logic               sweep_update
);

   localparam logic [TIMER_W-1:0] ONE        = TIMER_W'(1);
   localparam logic [TIMER_W-1:0] MUTE_LIMIT = TIMER_W'(MUTE_MIN);

   logic [TIMER_W-1:0] timer_reg;
   logic [TIMER_W-1:0] period_reg;
   logic [TIMER_W-1:0] period_next;
   logic [2:0]         seq_reg;
   logic               tick_en;
   logic               period_wr;
   logic               period_below_min;
   logic               sweep_fire;
   logic [TIMER_W-1:0] sweep_target;

   assign tick_en          = cpu_en & apu_clk;
   assign period_wr        = set_period_low | set_period_high;
   assign period_below_min = (period_reg < MUTE_LIMIT);

   assign next_step = tick_en & (timer_reg == '0);
   assign seq_step  = seq_reg;
   assign period    = period_reg;

   // Timer: reload from the period on expiry, otherwise count down one per tick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_reg <= '0;
      end else if (tick_en) begin
         if (timer_reg == '0) begin
            timer_reg <= period_reg;
         end else begin
            timer_reg <= timer_reg - ONE;
         end
      end
   end

   // Sequencer position steps backwards on each expiry; a high-period write restarts it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seq_reg <= '0;
      end else if (cpu_en) begin
         if (set_period_high) begin
            seq_reg <= '0;
         end else if (next_step) begin
            seq_reg <= seq_reg - 3'd1;
         end
      end
   end

   // Next period: a sweep retarget, overlaid by any CPU field writes (which also block the sweep)
   always_comb begin
      period_next = period_reg;
      if (sweep_fire) begin
         period_next = sweep_target;
      end
      if (set_period_low) begin
         period_next[7:0] = period_low_in;
      end
      if (set_period_high) begin
         period_next[TIMER_W-1:8] = period_high_in;
      end
   end

   // Period register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_reg <= '0;
      end else if (cpu_en) begin
         period_reg <= period_next;
      end
   end

`ifdef PULSE_SWEEP_UNIT_EN
   localparam logic [TIMER_W-1:0] NEG_INC = (NEG_ONES != 0) ? '0 : ONE;
   localparam logic [DIV_W-1:0]   DIV_ONE = DIV_W'(1);

   logic               sweep_en_reg;
   logic [DIV_W-1:0]   sweep_div_period_reg;
   logic               sweep_negate_reg;
   logic [SHIFT_W-1:0] sweep_shift_reg;
   logic [DIV_W-1:0]   divider_reg;
   logic               reload_reg;
   logic               sweep_update_reg;

   logic [TIMER_W-1:0] shifted;
   logic [TIMER_W-1:0] shifted_inv;
   logic [TIMER_W:0]   add_sum;
   logic [TIMER_W-1:0] neg_sum;
   logic               add_carry;

   assign shifted = period_reg >> sweep_shift_reg;

   genvar gi;
   generate
      for (gi = 0; gi < TIMER_W; gi = gi + 1) begin : g_inv
         assign shifted_inv[gi] = ~shifted[gi];
      end
   endgenerate

   // Add mode keeps the carry so an overflowing target can mute the channel;
   // negate mode wraps silently
   assign add_sum   = {1'b0, period_reg} + {1'b0, shifted};
   assign neg_sum   = period_reg + shifted_inv + NEG_INC;
   assign add_carry = add_sum[TIMER_W];

   assign mute         = (~sweep_negate_reg & add_carry) | period_below_min;
   assign sweep_target = sweep_negate_reg ? neg_sum : add_sum[TIMER_W-1:0];
   assign sweep_fire   = half_frame & (divider_reg == '0) & sweep_en_reg & ~mute
                         & (sweep_shift_reg != '0) & ~period_wr;
   assign sweep_update = sweep_update_reg;

   // Sweep configuration registers, loaded by a CPU sweep write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sweep_en_reg         <= 1'b0;
         sweep_div_period_reg <= '0;
         sweep_negate_reg     <= 1'b0;
         sweep_shift_reg      <= '0;
      end else if (cpu_en && sweep_write) begin
         sweep_en_reg         <= sweep_en_in;
         sweep_div_period_reg <= sweep_period_in;
         sweep_negate_reg     <= sweep_negate_in;
         sweep_shift_reg      <= sweep_shift_in;
      end
   end

   // Divider and reload flag; a sweep write sets the flag even on a half-frame tick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         divider_reg <= '0;
         reload_reg  <= 1'b0;
      end else if (cpu_en) begin
         if (half_frame) begin
            if ((divider_reg == '0) || reload_reg) begin
               divider_reg <= sweep_div_period_reg;
            end else begin
               divider_reg <= divider_reg - DIV_ONE;
            end
         end
         if (sweep_write) begin
            reload_reg <= 1'b1;
         end else if (half_frame) begin
            reload_reg <= 1'b0;
         end
      end
   end

   // One-cycle strobe marking the cycle after a sweep retarget
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sweep_update_reg <= 1'b0;
      end else if (cpu_en) begin
         sweep_update_reg <= sweep_fire;
      end
   end
`else
   logic unused_sweep_inputs;

   assign unused_sweep_inputs = ^{half_frame, sweep_write, sweep_en_in, sweep_period_in,
                                  sweep_negate_in, sweep_shift_in, (NEG_ONES != 0)};
   assign mute         = period_below_min;
   assign sweep_fire   = 1'b0;
   assign sweep_target = period_reg;
   assign sweep_update = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_timer_sweep.sv
// Scoreboard bench for pulse_timer_sweep: stimulus pushes expected strobes,
// a negedge monitor pops and compares them when next_step / sweep_update fire.
module tb_pulse_timer_sweep;

   localparam int TW           = 11;
   localparam int NEG_ONES_CFG = 0;

   logic          clk;
   logic          reset_n;
   logic          cpu_en;
   logic          apu_clk;
   logic          half_frame;
   logic          set_period_low;
   logic [7:0]    period_low_in;
   logic          set_period_high;
   logic [TW-9:0] period_high_in;
   logic          sweep_write;
   logic          sweep_en_in;
   logic [2:0]    sweep_period_in;
   logic          sweep_negate_in;
   logic [2:0]    sweep_shift_in;
   logic          next_step;
   logic [2:0]    seq_step;
   logic          mute;
   logic [TW-1:0] period;
   logic          sweep_update;

   pulse_timer_sweep #(
      .TIMER_W (TW),
      .SHIFT_W (3),
      .DIV_W   (3),
      .NEG_ONES(NEG_ONES_CFG),
      .MUTE_MIN(8)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cpu_en         (cpu_en),
      .apu_clk        (apu_clk),
      .half_frame     (half_frame),
      .set_period_low (set_period_low),
      .period_low_in  (period_low_in),
      .set_period_high(set_period_high),
      .period_high_in (period_high_in),
      .sweep_write    (sweep_write),
      .sweep_en_in    (sweep_en_in),
      .sweep_period_in(sweep_period_in),
      .sweep_negate_in(sweep_negate_in),
      .sweep_shift_in (sweep_shift_in),
      .next_step      (next_step),
      .seq_step       (seq_step),
      .mute           (mute),
      .period         (period),
      .sweep_update   (sweep_update)
   );

   typedef struct {
      logic [2:0] seq;
      int         cyc;
   } step_exp_t;

   step_exp_t     step_q[$];
   logic [TW-1:0] sweep_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;
   int            base;
   logic [2:0]    seq_tbl[4] = '{3'd0, 3'd7, 3'd6, 3'd5};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_period(input logic [7:0] lo, input logic [TW-9:0] hi);
      set_period_low  = 1'b1;
      set_period_high = 1'b1;
      period_low_in   = lo;
      period_high_in  = hi;
      tick();
      set_period_low  = 1'b0;
      set_period_high = 1'b0;
   endtask

   task automatic sweep_wr(input logic en, input logic [2:0] div, input logic neg, input logic [2:0] sh);
      sweep_write     = 1'b1;
      sweep_en_in     = en;
      sweep_period_in = div;
      sweep_negate_in = neg;
      sweep_shift_in  = sh;
      tick();
      sweep_write = 1'b0;
   endtask

   task automatic hf();
      half_frame = 1'b1;
      tick();
      half_frame = 1'b0;
      tick();
   endtask

   task automatic push_step(input logic [2:0] s, input int c);
      step_exp_t e;
      e.seq = s;
      e.cyc = c;
      step_q.push_back(e);
   endtask

   // Monitor: compare every observed strobe against the oldest expectation
   always @(negedge clk) begin : monitor
      step_exp_t     e;
      logic [TW-1:0] p;
      if (reset_n === 1'b1) begin
         if (next_step === 1'b1) begin
            check("next_step_expected", {31'd0, step_q.size() > 0}, 32'd1);
            if (step_q.size() > 0) begin
               e = step_q.pop_front();
               $display("step: cycle %0d seq_step %0d", cyc, seq_step);
               check("seq_step", {29'd0, seq_step}, {29'd0, e.seq});
               check("step_cycle", cyc, e.cyc);
            end
         end
         if (sweep_update === 1'b1) begin
            check("sweep_update_expected", {31'd0, sweep_q.size() > 0}, 32'd1);
            if (sweep_q.size() > 0) begin
               p = sweep_q.pop_front();
               $display("sweep: cycle %0d period 0x%0h", cyc, period);
               check("sweep_period", {21'd0, period}, {21'd0, p});
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n         = 1'b0;
      cpu_en          = 1'b1;
      apu_clk         = 1'b0;
      half_frame      = 1'b0;
      set_period_low  = 1'b0;
      period_low_in   = '0;
      set_period_high = 1'b0;
      period_high_in  = '0;
      sweep_write     = 1'b0;
      sweep_en_in     = 1'b0;
      sweep_period_in = '0;
      sweep_negate_in = 1'b0;
      sweep_shift_in  = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Reset state
      check("reset_period", {21'd0, period}, 32'd0);
      check("reset_seq_step", {29'd0, seq_step}, 32'd0);
      check("reset_mute", {31'd0, mute}, 32'd1);
      check("reset_sweep_update", {31'd0, sweep_update}, 32'd0);
      check("reset_next_step", {31'd0, next_step}, 32'd0);

      // Timer: period 0x0FE gives a strobe every 255 ticks, seq 0,7,6,5
      write_period(8'hFE, 3'h0);
      apu_clk = 1'b1;
      base    = cyc;
      for (int k = 0; k < 4; k++) push_step(seq_tbl[k], base + 255 * k);
      repeat (800) tick();
      apu_clk = 1'b0;
      tick();
      check("timer_steps_drained", step_q.size(), 32'd0);

`ifdef PULSE_SWEEP_UNIT_EN
      // Add sweep: 0x400 -> 0x600
      write_period(8'h00, 3'h4);
      check("period_0x400", {21'd0, period}, 32'h400);
      sweep_wr(1'b1, 3'd0, 1'b0, 3'd1);
      sweep_q.push_back(11'h600);
      hf();
      tick();

      // Add overflow: 0x700 mutes, sweep leaves period alone
      write_period(8'h00, 3'h7);
      check("carry_mute", {31'd0, mute}, 32'd1);
      hf();
      check("carry_period_held", {21'd0, period}, 32'h700);

      // Negate sweep from 0x100, twice
      write_period(8'h00, 3'h1);
      sweep_wr(1'b1, 3'd0, 1'b1, 3'd1);
      check("negate_no_mute", {31'd0, mute}, 32'd0);
      sweep_q.push_back((NEG_ONES_CFG != 0) ? 11'h07F : 11'h080);
      hf();
      sweep_q.push_back((NEG_ONES_CFG != 0) ? 11'h03F : 11'h040);
      hf();

      // Divider reload: write with half_frame, then 3,2,1,0, update on the 5th
      sweep_wr(1'b0, 3'd3, 1'b0, 3'd2);
      write_period(8'h00, 3'h1);
      sweep_write     = 1'b1;
      sweep_en_in     = 1'b1;
      sweep_period_in = 3'd3;
      sweep_negate_in = 1'b0;
      sweep_shift_in  = 3'd2;
      half_frame      = 1'b1;
      tick();
      sweep_write = 1'b0;
      half_frame  = 1'b0;
      tick();
      repeat (4) hf();
      check("divider_period_held", {21'd0, period}, 32'h100);
      sweep_q.push_back(11'h140);
      hf();

      // Period write in the same cycle as a due sweep suppresses the sweep
      sweep_wr(1'b1, 3'd0, 1'b0, 3'd1);
      hf();
      half_frame     = 1'b1;
      set_period_low = 1'b1;
      period_low_in  = 8'h20;
      tick();
      half_frame     = 1'b0;
      set_period_low = 1'b0;
      tick();
      check("suppressed_period", {21'd0, period}, 32'h120);
      sweep_q.push_back(11'h1B0);
      hf();
      check("sweeps_drained", sweep_q.size(), 32'd0);
`else
      // Sweep removed: sweep inputs have no effect on period or mute
      write_period(8'h00, 3'h4);
      sweep_wr(1'b1, 3'd0, 1'b0, 3'd1);
      hf();
      hf();
      check("nosweep_period", {21'd0, period}, 32'h400);
      write_period(8'h00, 3'h7);
      check("nosweep_mute", {31'd0, mute}, 32'd0);
`endif

      // Clock enable low blocks writes
      write_period(8'h34, 3'h2);
      cpu_en          = 1'b0;
      set_period_low  = 1'b1;
      set_period_high = 1'b1;
      period_low_in   = 8'h55;
      period_high_in  = 3'h5;
      tick();
      set_period_low  = 1'b0;
      set_period_high = 1'b0;
      cpu_en          = 1'b1;
      tick();
      check("cpu_en_hold", {21'd0, period}, 32'h234);

      // Mute threshold boundary
      write_period(8'h07, 3'h0);
      check("mute_0x007", {31'd0, mute}, 32'd1);
      write_period(8'h08, 3'h0);
      check("mute_0x008", {31'd0, mute}, 32'd0);

      // Asynchronous reset in the middle of a countdown
      write_period(8'h20, 3'h0);
      apu_clk = 1'b1;
      repeat (10) tick();
      #2;
      reset_n = 1'b0;
      apu_clk = 1'b0;
      #1;
      check("async_period", {21'd0, period}, 32'd0);
      check("async_seq_step", {29'd0, seq_step}, 32'd0);
      check("async_mute", {31'd0, mute}, 32'd1);
      check("async_sweep_update", {31'd0, sweep_update}, 32'd0);
      check("async_next_step", {31'd0, next_step}, 32'd0);
      tick();
      reset_n = 1'b1;
      repeat (5) tick();
      check("post_reset_period", {21'd0, period}, 32'd0);

      repeat (3) tick();
      check("final_steps_drained", step_q.size(), 32'd0);
      check("final_sweeps_drained", sweep_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
